// File: rtl/hazard_scoreboard_if.sv
// Issue/write-back/drain signal bundle between the decode stage and the
// register hazard scoreboard.
interface hazard_scoreboard_if;
  logic       issue_valid;
  logic [2:0] issue_sr1;
  logic [2:0] issue_sr2;
  logic       issue_sr1_used;
  logic       issue_sr2_used;
  logic [2:0] issue_dest;
  logic       issue_writes;
  logic       stall_in;
  logic       wb_valid;
  logic [2:0] wb_reg;
  logic       drain_req;
  logic       hazard_stall;
  logic       issue_fire;
  logic [7:0] pending;
  logic [2:0] inflight;
  logic       drain_done;
  logic       wb_error;

  modport master (
    output issue_valid, issue_sr1, issue_sr2, issue_sr1_used, issue_sr2_used,
           issue_dest, issue_writes, stall_in, wb_valid, wb_reg, drain_req,
    input  hazard_stall, issue_fire, pending, inflight, drain_done, wb_error
  );

  modport slave (
    input  issue_valid, issue_sr1, issue_sr2, issue_sr1_used, issue_sr2_used,
           issue_dest, issue_writes, stall_in, wb_valid, wb_reg, drain_req,
    output hazard_stall, issue_fire, pending, inflight, drain_done, wb_error
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard with issue stall, in-flight limit
// and a drain sequencer (RUN -> DRAIN -> DONE -> RUN).
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] MAX_INF = 3'(MAX_INFLIGHT);

  state_e     state_q, state_d;
  logic [1:0] cnt_q [8];
  logic [1:0] cnt_d [8];
  logic [2:0] inflight_q, inflight_d;
  logic [7:0] pending_q, pending_d;
  logic       wb_error_q, wb_error_d;
  logic       drain_done_q, drain_done_d;

  logic       src_hz, wr_hz, stall, fire, inc, dec;
  logic [7:0] inc_vec, dec_vec;

  // Hazards look only at registered counts: a same-cycle write-back does not clear them.
  assign src_hz = (sb.issue_sr1_used && (cnt_q[sb.issue_sr1] != 2'd0)) ||
                  (sb.issue_sr2_used && (cnt_q[sb.issue_sr2] != 2'd0));
  assign wr_hz  = sb.issue_writes &&
                  ((cnt_q[sb.issue_dest] == 2'd3) || (inflight_q == MAX_INF));
  assign stall  = (state_q != ST_RUN) || sb.stall_in ||
                  (sb.issue_valid && (src_hz || wr_hz));
  assign fire   = sb.issue_valid && !stall;
  assign inc    = fire && sb.issue_writes;
  assign dec    = sb.wb_valid && (cnt_q[sb.wb_reg] != 2'd0);

  assign inc_vec = inc ? (8'd1 << sb.issue_dest) : 8'd0;
  assign dec_vec = dec ? (8'd1 << sb.wb_reg) : 8'd0;

  assign sb.hazard_stall = stall;
  assign sb.issue_fire   = fire;
  assign sb.pending      = pending_q;
  assign sb.inflight     = inflight_q;
  assign sb.drain_done   = drain_done_q;
  assign sb.wb_error     = wb_error_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      pending_d[i] = (cnt_d[i] != 2'd0);
    end

    inflight_d = inflight_q;
    case ({inc, dec})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase

    wb_error_d = wb_error_q || (sb.wb_valid && (cnt_q[sb.wb_reg] == 2'd0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (sb.drain_req) state_d = ST_DRAIN;
        else              state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (inflight_q == 3'd0) state_d = ST_DONE;
        else                    state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= 2'd0;
      inflight_q   <= 3'd0;
      pending_q    <= 8'd0;
      state_q      <= ST_RUN;
      wb_error_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      inflight_q   <= inflight_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      wb_error_q   <= wb_error_d;
      drain_done_q <= drain_done_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4, SHALL set the maximum number of issued-but-not-written-back register-writing instructions (legal range 1..7).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  the decode stage holds an instruction requesting issue.
REQ-005 issue_sr1, issue_sr2  input  3 each  source register numbers of the decoding instruction.
REQ-006 issue_sr1_used, issue_sr2_used  input  1 each  the corresponding source is actually read.
REQ-007 issue_dest  input  3  final destination register (R7 already substituted for JSR/TRAP).
REQ-008 issue_writes  input  1  the instruction writes issue_dest.
REQ-009 stall_in  input  1  downstream backpressure; forces a stall.
REQ-010 wb_valid  input  1  the register file is written this cycle (load_regfile).
REQ-011 wb_reg  input  3  register written when wb_valid=1.
REQ-012 drain_req  input  1  level request to stop issue and empty the pipeline.
REQ-013 hazard_stall  output  1  stall to the decode stage (forces a NOP control word and dest 000).
REQ-014 issue_fire  output  1  the instruction issues this cycle.
REQ-015 pending  output  8  bit n = 1 iff register Rn has a nonzero pending count.
REQ-016 inflight  output  3  count of outstanding register writes.
REQ-017 drain_done  output  1  one-cycle pulse when a drain completes.
REQ-018 wb_error  output  1  sticky flag set on a write-back with no matching pending write.

Function
REQ-019 Each register Rn SHALL have a 2-bit pending counter cnt[n] (0..3).
REQ-020 hazard_stall SHALL be computed combinationally from registered state and current inputs only; a same-cycle wb_valid SHALL NOT remove a hazard (no write-through bypass).
REQ-021 hazard_stall SHALL be 1 when state is DRAIN or DONE, or stall_in=1, or issue_valid=1 and any of: (sr1_used and cnt[sr1]!=0), (sr2_used and cnt[sr2]!=0), (issue_writes and cnt[dest]==3), (issue_writes and inflight==MAX_INFLIGHT).
REQ-022 hazard_stall SHALL be 0 when issue_valid=0 and none of the state/stall_in conditions hold.
REQ-023 issue_fire SHALL equal issue_valid and not hazard_stall.
REQ-024 On issue_fire with issue_writes=1, cnt[issue_dest] and inflight SHALL each increment by 1 at the next edge.
REQ-025 On wb_valid with cnt[wb_reg]!=0, cnt[wb_reg] and inflight SHALL each decrement by 1 at the next edge.
REQ-026 Simultaneous increment and decrement of the same register SHALL leave cnt unchanged; inflight SHALL follow the net change independently.
REQ-027 wb_valid with cnt[wb_reg]==0 SHALL leave all counters unchanged and set wb_error, which SHALL stay 1 until reset.
REQ-028 Counters SHALL never wrap; REQ-021 guarantees no increment at 3 or at MAX_INFLIGHT.
REQ-029 FSM states RUN, DRAIN, DONE; RUN->DRAIN when drain_req=1; DRAIN->DONE when inflight==0 (evaluated on the registered value); DONE->RUN unconditionally after one cycle.
REQ-030 drain_done SHALL be 1 exactly in the DONE state, i.e. for one cycle per drain.
REQ-031 drain_req asserted while in DRAIN or DONE SHALL have no additional effect; it is re-sampled in RUN.
REQ-032 Write-backs SHALL be accepted and counted in every state.

Reset
REQ-033 While rst_n=0: all cnt=0, inflight=0, state=RUN, wb_error=0, drain_done=0, pending=8'h00; hazard_stall and issue_fire follow REQ-021/023 from this state.
REQ-034 Reset asserted mid-operation SHALL discard all pending state immediately, without waiting for a clock edge.

Verification
REQ-035 Reset, then issue ADD R1 (writes, dest=1) -> issue_fire=1, next cycle pending=8'h02, inflight=1; dependent ADD reading R1 -> hazard_stall=1 until the cycle after wb_valid, wb_reg=1.
REQ-036 Issue 3 writes to R2 with no write-back -> cnt[2]=3; a 4th write to R2 stalls; a write to R3 issues only if inflight<MAX_INFLIGHT (MAX_INFLIGHT=4: R3 issues, next write stalls).
REQ-037 Issue a write to R4 while wb_valid, wb_reg=4 with cnt[4]=1 in the same cycle -> cnt[4] stays 1, inflight unchanged, pending[4]=1.
REQ-038 wb_valid, wb_reg=5 with cnt[5]=0 -> wb_error=1 and stays 1; counters unchanged.
REQ-039 inflight=2, drain_req=1 -> hazard_stall=1; two write-backs -> drain_done pulses for 1 cycle the cycle after inflight reaches 0, then RUN, and issue resumes.
REQ-040 Assert rst_n=0 asynchronously mid-drain with inflight=3 -> pending=0, inflight=0, state RUN, no drain_done pulse.
